// File: rtl/wr_result_collector.sv
// rtl/wr_result_collector.sv - result word FIFO that collects a wrapper frame and drains it on done
module wr_result_collector #(
  parameter int DATA_W = 16,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              done_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              frame_done
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, FLAG} state_t;

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign out_valid  = (state == DRAIN) && !empty;
  assign frame_done = (state == FLAG);
  assign out_data   = mem[rd_ptr];
  // A push while full is rejected even if a pop frees a slot this cycle.
  assign push       = wr_req && !full;
  assign pop        = out_valid && out_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (done_in)   state_nx = DRAIN;
        else if (push) state_nx = COLLECT;
      end
      COLLECT: begin
        if (done_in) state_nx = DRAIN;
      end
      DRAIN: begin
        if ((count == ONE_C && pop && !push) || (empty && !push))
          state_nx = FLAG;
      end
      FLAG: begin
        if (push || !empty) state_nx = COLLECT;
        else                state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
      if (wr_req && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_wr_result_collector.sv
// tb/tb_wr_result_collector.sv - directed scenario bench for wr_result_collector
module tb_wr_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req;
  logic [15:0] wr_data;
  logic        done_in;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  wr_result_collector #(.DATA_W(16), .AW(2)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data), .done_in(done_in),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .count(count),
    .full(full), .empty(empty), .overflow(overflow), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] d);
    wr_req  = 1'b1;
    wr_data = d;
    cyc();
    wr_req  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_req = 1'b0; done_in = 1'b0; out_ready = 1'b0; wr_data = '0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_basic_frame();
    logic [15:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) push_word(16'h0011 * 16'(i + 1));
    checks++; if (count !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL basic_fill count %0d full %b exp 4 1", count, full); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_collect_valid got %b exp 0", out_valid); end
    done_in = 1'b1; out_ready = 1'b1;
    cyc();
    done_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_d = 16'h0011 * 16'(i + 1);
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin errors++; $display("FAIL basic_drain%0d valid %b data %h exp 1 %h", i, out_valid, out_data, exp_d); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL basic_early_done%0d got %b exp 0", i, frame_done); end
      cyc();
    end
    checks++; if (frame_done !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_flag done %b valid %b exp 1 0", frame_done, out_valid); end
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL basic_empty count %0d empty %b exp 0 1", count, empty); end
    cyc();
    checks++; if (frame_done !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_idle done %b valid %b exp 0 0", frame_done, out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [15:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) push_word(16'h0011 * 16'(i + 1));
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before got %b exp 0", overflow); end
    push_word(16'h0055);
    checks++; if (overflow !== 1'b1 || full !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL ovf_flags ovf %b full %b count %0d exp 1 1 4", overflow, full, count); end
    done_in = 1'b1; out_ready = 1'b1;
    cyc();
    done_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_d = 16'h0011 * 16'(i + 1);
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin errors++; $display("FAIL ovf_drain%0d valid %b data %h exp 1 %h", i, out_valid, out_data, exp_d); end
      cyc();
    end
    checks++; if (frame_done !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_end done %b ovf %b exp 1 1", frame_done, overflow); end
    out_ready = 1'b0;
    cyc();
  endtask

  task automatic test_stall();
    logic [6:0]  pat;
    logic [15:0] exp_d;
    int          popped;
    do_reset();
    for (int i = 0; i < 4; i++) push_word(16'h1001 + 16'(i));
    done_in = 1'b1;
    cyc();
    done_in = 1'b0;
    pat = 7'b1011001;
    popped = 0;
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[6 - i];
      exp_d = 16'h1001 + 16'(popped);
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin errors++; $display("FAIL stall_c%0d valid %b data %h exp 1 %h", i, out_valid, out_data, exp_d); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL stall_early_done%0d got %b exp 0", i, frame_done); end
      if (pat[6 - i]) popped++;
      cyc();
    end
    out_ready = 1'b0;
    checks++; if (frame_done !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL stall_end done %b count %0d exp 1 0", frame_done, count); end
    cyc();
  endtask

  task automatic test_simul_push_pop();
    do_reset();
    push_word(16'h2001);
    push_word(16'h2002);
    done_in = 1'b1;
    cyc();
    done_in = 1'b0;
    checks++; if (count !== 3'd2 || out_data !== 16'h2001) begin errors++; $display("FAIL simul_pre count %0d data %h exp 2 2001", count, out_data); end
    out_ready = 1'b1; wr_req = 1'b1; wr_data = 16'hAAAA;
    cyc();
    wr_req = 1'b0;
    checks++; if (count !== 3'd2 || out_data !== 16'h2002) begin errors++; $display("FAIL simul_count count %0d data %h exp 2 2002", count, out_data); end
    cyc();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hAAAA || count !== 3'd1) begin errors++; $display("FAIL simul_tail valid %b data %h count %0d exp 1 aaaa 1", out_valid, out_data, count); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL simul_early_done got %b exp 0", frame_done); end
    cyc();
    checks++; if (frame_done !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL simul_end done %b count %0d exp 1 0", frame_done, count); end
    out_ready = 1'b0;
    cyc();
  endtask

  // Runs without reset after test_simul_push_pop so both pointers start at 3 and wrap.
  task automatic test_back_to_back();
    int pulses;
    logic [15:0] exp_d;
    pulses = 0;
    for (int i = 0; i < 4; i++) push_word(16'h3001 + 16'(i));
    done_in = 1'b1; out_ready = 1'b1;
    cyc();
    done_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_d = 16'h3001 + 16'(i);
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin errors++; $display("FAIL b2b_f1_%0d valid %b data %h exp 1 %h", i, out_valid, out_data, exp_d); end
      cyc();
    end
    if (frame_done === 1'b1) pulses++;
    push_word(16'h4001);
    if (frame_done === 1'b1) pulses++;
    for (int i = 1; i < 4; i++) push_word(16'h4001 + 16'(i));
    checks++; if (count !== 3'd4 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_f2_fill count %0d valid %b exp 4 0", count, out_valid); end
    done_in = 1'b1;
    cyc();
    done_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_d = 16'h4001 + 16'(i);
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin errors++; $display("FAIL b2b_f2_%0d valid %b data %h exp 1 %h", i, out_valid, out_data, exp_d); end
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      if (frame_done === 1'b1) pulses++;
      cyc();
    end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", pulses); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int i = 0; i < 5; i++) push_word(16'h5001 + 16'(i));
    done_in = 1'b1;
    cyc();
    done_in = 1'b0;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++; if (count !== 3'd3 || overflow !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre count %0d ovf %b valid %b exp 3 1 1", count, overflow, out_valid); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_post count %0d valid %b ovf %b done %b exp 0 0 0 0", count, out_valid, overflow, frame_done); end
    cyc();
    checks++; if (frame_done !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL rstmid_after done %b empty %b exp 0 1", frame_done, empty); end
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b0; wr_data = '0; done_in = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic_frame();
    test_overflow();
    test_stall();
    test_simul_push_pop();
    test_back_to_back();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
